// File: rtl/demux_1to4_tdm_pkg.sv
// Shared TDM definitions: slot-index encoding and frame-lock FSM states,
// common to the mux (transmit) and demux (receive) blocks.
package demux_1to4_tdm_pkg;

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-4 slot index counter; a load forces the index to slot 1 because the
// sample that triggers a load is always consumed as slot 0.
import demux_1to4_tdm_pkg::*;

module tdm_slot_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_one,
  input  logic       inc,
  output logic [1:0] idx
);

  always_ff @(posedge clk) begin
    if (rst)
      idx <= SLOT_A;
    else if (load_one)
      idx <= SLOT_B;
    else if (inc)
      idx <= idx + 2'd1;
  end

endmodule

// File: rtl/demux_1to4_tdm.sv
// Receive-side 1-to-4 TDM demultiplexer: locks to the sync marker, gathers four
// slots into capture registers and publishes a complete frame on A..D at once.
import demux_1to4_tdm_pkg::*;

module demux_1to4_tdm #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in,
  input  logic         valid,
  input  logic         sync,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [W-1:0] C,
  output logic [W-1:0] D,
  output logic         a,
  output logic         b,
  output logic         frame_valid,
  output logic         sync_err
);

  state_t       state, state_next;
  logic [1:0]   idx;
  logic         load_one, inc, cap_en, load_frame, err;
  logic [1:0]   cap_sel;
  logic [W-1:0] slot0, slot1, slot2;

  tdm_slot_counter u_slot_counter (
    .clk      (clk),
    .rst      (rst),
    .load_one (load_one),
    .inc      (inc),
    .idx      (idx)
  );

  assign a = idx[1];
  assign b = idx[0];

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == IDLE && valid && sync)
      state_next = RUN;
  end

  // A sync seen away from slot 0 restarts the frame instead of completing it.
  always_comb begin
    load_one   = 1'b0;
    inc        = 1'b0;
    cap_en     = 1'b0;
    cap_sel    = SLOT_A;
    load_frame = 1'b0;
    err        = 1'b0;
    if (valid) begin
      if (state == IDLE) begin
        if (sync) begin
          load_one = 1'b1;
          cap_en   = 1'b1;
        end
      end else if (sync && idx != SLOT_A) begin
        err      = 1'b1;
        load_one = 1'b1;
        cap_en   = 1'b1;
      end else begin
        inc        = 1'b1;
        cap_en     = 1'b1;
        cap_sel    = idx;
        load_frame = (idx == SLOT_D);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0       <= '0;
      slot1       <= '0;
      slot2       <= '0;
      A           <= '0;
      B           <= '0;
      C           <= '0;
      D           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      if (cap_en) begin
        case (cap_sel)
          SLOT_A:  slot0 <= in;
          SLOT_B:  slot1 <= in;
          SLOT_C:  slot2 <= in;
          default: ;
        endcase
      end
      // The slot-3 sample bypasses the capture registers so the frame lands whole.
      if (load_frame) begin
        A <= slot0;
        B <= slot1;
        C <= slot2;
        D <= in;
      end
      frame_valid <= load_frame;
      sync_err    <= err;
    end
  end

endmodule

// File: tb/tb_demux_1to4_tdm.sv
// Directed self-checking bench for demux_1to4_tdm (W=1); expected values are
// hand-computed per step and compared with immediate assertions.
module tb_demux_1to4_tdm;

  logic clk = 1'b0;
  logic rst, valid, sync;
  logic [0:0] din;
  logic [0:0] A, B, C, D;
  logic a, b, frame_valid, sync_err;

  int checks = 0;
  int passed = 0;

  demux_1to4_tdm #(.W(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (din),
    .valid       (valid),
    .sync        (sync),
    .A           (A),
    .B           (B),
    .C           (C),
    .D           (D),
    .a           (a),
    .b           (b),
    .frame_valid (frame_valid),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic v, input logic s, input logic d);
    rst   = r;
    valid = v;
    sync  = s;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  // data is {A,B,C,D}; ab is {a,b}
  task automatic checkOutput(input string tag, input logic [3:0] data, input logic [1:0] ab,
                             input logic fv, input logic se);
    logic [7:0] obs, exp;
    obs = {A, B, C, D, a, b, frame_valid, sync_err};
    exp = {data, ab, fv, se};
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: {ABCD,ab,fv,se} observed=%b required=%b", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; sync = 1'b0; din = 1'b0;

    applyStimulus(1, 0, 0, 0);
    checkOutput("reset", 4'b0000, 2'd0, 0, 0);

    // No sync after reset: samples ignored
    applyStimulus(0, 1, 0, 1);
    checkOutput("idle_nosync_1", 4'b0000, 2'd0, 0, 0);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("idle_nosync_3", 4'b0000, 2'd0, 0, 0);

    // Frame 1,0,1,1
    applyStimulus(0, 1, 1, 1);
    checkOutput("f1011_s0", 4'b0000, 2'd1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("f1011_s1", 4'b0000, 2'd2, 0, 0);
    applyStimulus(0, 1, 0, 1);
    checkOutput("f1011_s2", 4'b0000, 2'd3, 0, 0);
    applyStimulus(0, 1, 0, 1);
    checkOutput("f1011_s3", 4'b1011, 2'd0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("f1011_hold", 4'b1011, 2'd0, 0, 0);

    // Frame 1,1,0,0 then sync at slot 2 of the next frame
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("f1100_s3", 4'b1100, 2'd0, 1, 0);
    applyStimulus(0, 1, 1, 1);
    checkOutput("sync_at_slot0", 4'b1100, 2'd1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("next_s1", 4'b1100, 2'd2, 0, 0);
    applyStimulus(0, 1, 1, 1);
    checkOutput("sync_err", 4'b1100, 2'd1, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("sync_err_clear", 4'b1100, 2'd1, 0, 0);

    // Mid-frame reset clears everything
    applyStimulus(1, 0, 0, 0);
    checkOutput("reset_midframe", 4'b0000, 2'd0, 0, 0);

    // Frame 0,1,1,0 with gaps of 2,0,3 cycles
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("gap_hold", 4'b0000, 2'd1, 0, 0);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("gap_s2", 4'b0000, 2'd3, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("gap_before_s3", 4'b0000, 2'd3, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("gap_s3", 4'b0110, 2'd0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("gap_after", 4'b0110, 2'd0, 0, 0);

    // Reset after slot 1, with valid and sync asserted alongside it
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("pre_reset", 4'b0110, 2'd2, 0, 0);
    applyStimulus(1, 1, 1, 1);
    checkOutput("reset_priority", 4'b0000, 2'd0, 0, 0);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("post_reset_ignored", 4'b0000, 2'd0, 0, 0);

    // Back-to-back frames 0,1,0,1 then 1,0,1,0
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 1);
    checkOutput("b2b_f1", 4'b0101, 2'd0, 1, 0);
    applyStimulus(0, 1, 1, 1);
    checkOutput("b2b_c1", 4'b0101, 2'd1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("b2b_c2", 4'b0101, 2'd2, 0, 0);
    applyStimulus(0, 1, 0, 1);
    checkOutput("b2b_c3", 4'b0101, 2'd3, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("b2b_f2", 4'b1010, 2'd0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("b2b_end", 4'b1010, 2'd0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/demux_1to4_tdm.md
DEMUX_1TO4_TDM -- requirements
Module: demux_1to4_tdm

Interface
REQ-001 Parameter: W, default 1, data width of the serial input and of each slot output.
REQ-002 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in  input  W  time-multiplexed serial data, one slot per valid cycle.
REQ-005 valid  input  1  in SHALL be sampled only in cycles where valid=1.
REQ-006 sync  input  1  frame marker; meaningful only with valid=1; marks the current sample as slot 0.
REQ-007 A  output  W  frame slot 0 (select a=0,b=0).
REQ-008 B  output  W  frame slot 1 (a=0,b=1).
REQ-009 C  output  W  frame slot 2 (a=1,b=0).
REQ-010 D  output  W  frame slot 3 (a=1,b=1).
REQ-011 a  output  1  MSB of the slot index expected next.
REQ-012 b  output  1  LSB of the slot index expected next.
REQ-013 frame_valid  output  1  one-cycle pulse: A..D were just loaded with a complete frame.
REQ-014 sync_err  output  1  one-cycle pulse: sync arrived while the slot index was not 0.

Function
REQ-015 The block SHALL be the receive-side inverse of the team's 4-to-1 mux: slot index {a,b} = 2'bAB selects which of A..D the sample belongs to, using the same encoding as the mux.
REQ-016 FSM states: IDLE (no frame lock) and RUN (locked); reset SHALL enter IDLE.
REQ-017 In IDLE, valid=1 with sync=0 SHALL be ignored; valid=1 with sync=1 SHALL capture in into slot 0, set {a,b}=1, and go to RUN.
REQ-018 In RUN, each valid=1 with sync=0 SHALL capture in into the internal register for slot {a,b} and increment {a,b} modulo 4 (3 wraps to 0).
REQ-019 Cycles with valid=0 SHALL leave all state and outputs unchanged.
REQ-020 A..D SHALL be double-buffered: they update only when the slot-3 sample is captured, loading {slot0,slot1,slot2,in} simultaneously on that same edge.
REQ-021 frame_valid SHALL be 1 for exactly the cycle following the slot-3 capture edge, with zero additional latency to A..D.
REQ-022 In RUN, valid=1, sync=1 with {a,b}=0 SHALL behave as a normal slot-0 capture, with no error.
REQ-023 In RUN, valid=1, sync=1 with {a,b}!=0 SHALL pulse sync_err for one cycle, discard the partial frame (A..D unchanged, no frame_valid), capture in as slot 0, and set {a,b}=1.
REQ-024 Partial-frame capture registers SHALL never be visible on A..D.
REQ-025 frame_valid and sync_err SHALL never be 1 in the same cycle.

Reset
REQ-026 While rst=1, at the next clk edge: A=B=C=D=0, a=b=0, frame_valid=0, sync_err=0, capture registers=0, state=IDLE.
REQ-027 rst SHALL take priority over valid and sync in the same cycle.
REQ-028 Reset in mid-frame SHALL drop the partial frame; after reset, a new sync is required.

Structure
REQ-029 A shared package SHALL hold the slot-index constants (SLOT_A=0..SLOT_D=3) and the FSM state encoding (IDLE, RUN), shared with the mux-side blocks.
REQ-030 The modulo-4 slot counter with load-to-1 SHALL be one sub-module, tdm_slot_counter; all other logic SHALL be in demux_1to4_tdm.

Verification
REQ-031 Reset, then valid with sync and in=1,0,1,1 (W=1) -> A=1, B=0, C=1, D=1 after the 4th edge; frame_valid is high for 1 cycle; {a,b}=0.
REQ-032 valid=1 with sync=0 and in=1 for 3 cycles after reset -> state stays IDLE; A..D=0; {a,b}=0; no pulses.
REQ-033 Frame 1,1,0,0, then sync at slot 2 of the next frame -> sync_err pulses 1 cycle; A..D stay 1,1,0,0; {a,b}=1.
REQ-034 Frame with valid=0 gaps of 0-3 cycles between samples -> A..D equal the gap-free result; frame_valid fires once, on the slot-3 capture.
REQ-035 rst asserted after slot 1 of a frame -> all outputs 0 on the next edge; later samples without sync are ignored.
REQ-036 Back-to-back frames 0,1,0,1 then 1,0,1,0 with continuous valid -> frame_valid pulses exactly 4 cycles apart; outputs load 0,1,0,1 then 1,0,1,0.
